core_sram_bridge: RTL and testbench

- Sits directly downstream of the CPU core. Consumes the core's SRAM-style instruction port (inst_sram_*) and data port (data_sram_*).
- Serialises both ports onto one shared variable-latency request/response memory bus with an addr_ok/data_ok handshake.
- Stalls the core through stall_req, which feeds the CTRL stall logic, until every request issued in a cycle has completed.
- Returns read data to the core on registered outputs.

---
 rtl/core_sram_bridge_if.sv | 24 ++
 rtl/core_sram_bridge.sv | 102 ++++++++++
 tb/tb_core_sram_bridge.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/core_sram_bridge_if.sv
// rtl/core_sram_bridge_if.sv - shared request/response memory bus with addr_ok/data_ok handshake
interface core_sram_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  mem_req;
   logic                  mem_wr;
   logic [DATA_W/8-1:0]   mem_wstrb;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_addr_ok;
   logic                  mem_data_ok;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
      input  mem_addr_ok, mem_data_ok, mem_rdata
   );

   modport slave (
      input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
      output mem_addr_ok, mem_data_ok, mem_rdata
   );
endinterface

// File: rtl/core_sram_bridge.sv
// rtl/core_sram_bridge.sv - serialises core inst/data SRAM ports onto one memory bus, stalling the core
module core_sram_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 inst_sram_en,
   input  logic [ADDR_W-1:0]    inst_sram_addr,
   output logic [DATA_W-1:0]    inst_sram_rdata,
   input  logic                 data_sram_en,
   input  logic [DATA_W/8-1:0]  data_sram_wen,
   input  logic [ADDR_W-1:0]    data_sram_addr,
   input  logic [DATA_W-1:0]    data_sram_wdata,
   output logic [DATA_W-1:0]    data_sram_rdata,
   output logic                 stall_req,
   core_sram_bridge_if.master   mem
);
   localparam int WB = DATA_W / 8;

   typedef enum logic [2:0] {IDLE, D_REQ, D_WAIT, I_REQ, I_WAIT, DONE} state_t;

   state_t            state, state_nxt;
   logic              i_pend;
   logic [ADDR_W-1:0] i_addr;
   logic [ADDR_W-1:0] d_addr;
   logic [WB-1:0]     d_wen;
   logic [DATA_W-1:0] d_wdata;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Request fields are captured once in IDLE; everything downstream uses only these copies.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         i_pend          <= 1'b0;
         i_addr          <= '0;
         d_addr          <= '0;
         d_wen           <= '0;
         d_wdata         <= '0;
         inst_sram_rdata <= '0;
         data_sram_rdata <= '0;
      end else begin
         if (state == IDLE && (inst_sram_en || data_sram_en)) begin
            i_pend  <= inst_sram_en;
            i_addr  <= inst_sram_addr;
            d_addr  <= data_sram_addr;
            d_wen   <= data_sram_en ? data_sram_wen : '0;
            d_wdata <= data_sram_wdata;
         end
         if (state == D_WAIT && mem.mem_data_ok && d_wen == '0)
            data_sram_rdata <= mem.mem_rdata;
         if (state == I_WAIT && mem.mem_data_ok)
            inst_sram_rdata <= mem.mem_rdata;
      end
   end

   always_comb begin
      state_nxt     = state;
      stall_req     = 1'b0;
      mem.mem_req   = 1'b0;
      mem.mem_wr    = 1'b0;
      mem.mem_wstrb = '0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      case (state)
         IDLE: begin
            stall_req = inst_sram_en | data_sram_en;
            if (data_sram_en)      state_nxt = D_REQ;
            else if (inst_sram_en) state_nxt = I_REQ;
         end
         D_REQ: begin
            stall_req     = 1'b1;
            mem.mem_req   = 1'b1;
            mem.mem_wr    = |d_wen;
            mem.mem_wstrb = d_wen;
            mem.mem_addr  = d_addr;
            mem.mem_wdata = d_wdata;
            if (mem.mem_addr_ok) state_nxt = D_WAIT;
         end
         D_WAIT: begin
            stall_req = 1'b1;
            if (mem.mem_data_ok) state_nxt = i_pend ? I_REQ : DONE;
         end
         I_REQ: begin
            stall_req    = 1'b1;
            mem.mem_req  = 1'b1;
            mem.mem_addr = i_addr;
            if (mem.mem_addr_ok) state_nxt = I_WAIT;
         end
         I_WAIT: begin
            stall_req = 1'b1;
            if (mem.mem_data_ok) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (rst) stall_req = 1'b0;
   end
endmodule

// File: tb/tb_core_sram_bridge.sv
// tb/tb_core_sram_bridge.sv - directed self-checking bench for core_sram_bridge
module tb_core_sram_bridge;
   logic        clk = 1'b0;
   logic        rst;
   logic        inst_sram_en;
   logic [31:0] inst_sram_addr;
   logic [31:0] inst_sram_rdata;
   logic        data_sram_en;
   logic [3:0]  data_sram_wen;
   logic [31:0] data_sram_addr;
   logic [31:0] data_sram_wdata;
   logic [31:0] data_sram_rdata;
   logic        stall_req;

   int vectors = 0;
   int miscompares = 0;
   int n_acc = 0;
   int acc0;

   core_sram_bridge_if #(.ADDR_W(32), .DATA_W(32)) mem ();

   core_sram_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk             (clk),
      .rst             (rst),
      .inst_sram_en    (inst_sram_en),
      .inst_sram_addr  (inst_sram_addr),
      .inst_sram_rdata (inst_sram_rdata),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .data_sram_rdata (data_sram_rdata),
      .stall_req       (stall_req),
      .mem             (mem)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem.mem_req && mem.mem_addr_ok) n_acc <= n_acc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic bus(input logic aok, input logic dok, input logic [31:0] rd);
      mem.mem_addr_ok = aok;
      mem.mem_data_ok = dok;
      mem.mem_rdata   = rd;
   endtask

   task automatic next_cycle();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      inst_sram_en = 1'b1; inst_sram_addr = 32'h0;
      data_sram_en = 1'b0; data_sram_wen = 4'h0;
      data_sram_addr = 32'h0; data_sram_wdata = 32'h0;
      bus(1'b0, 1'b0, 32'h0);

      // reset state
      next_cycle(); #1;
      chk("rst_stall", {31'b0, stall_req}, 32'h0);
      chk("rst_req", {31'b0, mem.mem_req}, 32'h0);
      chk("rst_addr", mem.mem_addr, 32'h0);
      chk("rst_irdata", inst_sram_rdata, 32'h0);
      chk("rst_drdata", data_sram_rdata, 32'h0);
      next_cycle(); rst = 1'b0; inst_sram_en = 1'b0;

      // single fetch, minimum latency
      next_cycle(); acc0 = n_acc;
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0000; bus(1'b1, 1'b0, 32'h0); #1;
      chk("f1_idle_stall", {31'b0, stall_req}, 32'h1);
      chk("f1_idle_req", {31'b0, mem.mem_req}, 32'h0);
      next_cycle(); #1;
      chk("f1_req", {31'b0, mem.mem_req}, 32'h1);
      chk("f1_wr", {31'b0, mem.mem_wr}, 32'h0);
      chk("f1_addr", mem.mem_addr, 32'hBFC0_0000);
      chk("f1_req_stall", {31'b0, stall_req}, 32'h1);
      next_cycle(); bus(1'b0, 1'b1, 32'h3C08_BFAF); #1;
      chk("f1_wait_req", {31'b0, mem.mem_req}, 32'h0);
      chk("f1_wait_stall", {31'b0, stall_req}, 32'h1);
      next_cycle(); bus(1'b0, 1'b0, 32'h0); inst_sram_en = 1'b0; #1;
      chk("f1_done_stall", {31'b0, stall_req}, 32'h0);
      chk("f1_irdata", inst_sram_rdata, 32'h3C08_BFAF);
      chk("f1_nacc", n_acc - acc0, 32'd1);

      // fetch + load in the same cycle: data first
      next_cycle(); acc0 = n_acc;
      inst_sram_en = 1'b1; inst_sram_addr = 32'hBFC0_0004;
      data_sram_en = 1'b1; data_sram_wen = 4'h0; data_sram_addr = 32'h8000_0010;
      bus(1'b1, 1'b0, 32'h0); #1;
      chk("f2_idle_stall", {31'b0, stall_req}, 32'h1);
      next_cycle(); #1;
      chk("f2_dreq_addr", mem.mem_addr, 32'h8000_0010);
      chk("f2_dreq_wr", {31'b0, mem.mem_wr}, 32'h0);
      chk("f2_dreq_req", {31'b0, mem.mem_req}, 32'h1);
      next_cycle(); bus(1'b0, 1'b1, 32'h1122_3344); #1;
      chk("f2_dwait_stall", {31'b0, stall_req}, 32'h1);
      chk("f2_dwait_req", {31'b0, mem.mem_req}, 32'h0);
      next_cycle(); bus(1'b1, 1'b0, 32'h0); #1;
      chk("f2_ireq_addr", mem.mem_addr, 32'hBFC0_0004);
      chk("f2_ireq_stall", {31'b0, stall_req}, 32'h1);
      chk("f2_drdata", data_sram_rdata, 32'h1122_3344);
      next_cycle(); bus(1'b0, 1'b1, 32'h2409_0001); #1;
      chk("f2_iwait_stall", {31'b0, stall_req}, 32'h1);
      chk("f2_iwait_irdata_old", inst_sram_rdata, 32'h3C08_BFAF);
      next_cycle(); bus(1'b0, 1'b0, 32'h0); inst_sram_en = 1'b0; data_sram_en = 1'b0; #1;
      chk("f2_done_stall", {31'b0, stall_req}, 32'h0);
      chk("f2_irdata", inst_sram_rdata, 32'h2409_0001);
      chk("f2_drdata_done", data_sram_rdata, 32'h1122_3344);
      chk("f2_nacc", n_acc - acc0, 32'd2);

      // store with addr_ok delayed 4 cycles
      next_cycle(); acc0 = n_acc;
      data_sram_en = 1'b1; data_sram_wen = 4'b0011;
      data_sram_addr = 32'h8000_0020; data_sram_wdata = 32'hDEAD_BEEF;
      bus(1'b0, 1'b0, 32'h0); #1;
      chk("st_idle_stall", {31'b0, stall_req}, 32'h1);
      for (int i = 0; i < 4; i++) begin
         next_cycle(); bus(i == 3, 1'b0, 32'h0); #1;
         chk("st_req", {31'b0, mem.mem_req}, 32'h1);
         chk("st_wr", {31'b0, mem.mem_wr}, 32'h1);
         chk("st_wstrb", {28'b0, mem.mem_wstrb}, 32'h3);
         chk("st_addr", mem.mem_addr, 32'h8000_0020);
         chk("st_wdata", mem.mem_wdata, 32'hDEAD_BEEF);
      end
      next_cycle(); bus(1'b0, 1'b1, 32'hFFFF_FFFF); #1;
      chk("st_wait_req", {31'b0, mem.mem_req}, 32'h0);
      next_cycle(); bus(1'b0, 1'b0, 32'h0); data_sram_en = 1'b0; data_sram_wen = 4'h0; #1;
      chk("st_done_stall", {31'b0, stall_req}, 32'h0);
      chk("st_drdata_kept", data_sram_rdata, 32'h1122_3344);
      chk("st_nacc", n_acc - acc0, 32'd1);

      // load with data_ok 6 cycles after acceptance
      next_cycle(); acc0 = n_acc;
      data_sram_en = 1'b1; data_sram_addr = 32'h8000_0030; bus(1'b1, 1'b0, 32'h0); #1;
      next_cycle(); #1;
      chk("lw_req", {31'b0, mem.mem_req}, 32'h1);
      for (int i = 0; i < 6; i++) begin
         next_cycle(); bus(1'b0, i == 5, (i == 5) ? 32'h5566_7788 : 32'h0); #1;
         chk("lw_wait_stall", {31'b0, stall_req}, 32'h1);
         chk("lw_wait_req", {31'b0, mem.mem_req}, 32'h0);
      end
      next_cycle(); bus(1'b0, 1'b0, 32'h0); data_sram_en = 1'b0; #1;
      chk("lw_done_stall", {31'b0, stall_req}, 32'h0);
      chk("lw_drdata", data_sram_rdata, 32'h5566_7788);
      chk("lw_nacc", n_acc - acc0, 32'd1);

      // reset in D_WAIT, late data_ok ignored
      next_cycle();
      data_sram_en = 1'b1; data_sram_addr = 32'h8000_0040; bus(1'b1, 1'b0, 32'h0);
      next_cycle();
      next_cycle(); bus(1'b0, 1'b0, 32'h0); #1;
      rst = 1'b1; #1;
      chk("rs_stall", {31'b0, stall_req}, 32'h0);
      chk("rs_req", {31'b0, mem.mem_req}, 32'h0);
      chk("rs_irdata", inst_sram_rdata, 32'h0);
      chk("rs_drdata", data_sram_rdata, 32'h0);
      next_cycle(); rst = 1'b0; data_sram_en = 1'b0;
      next_cycle(); bus(1'b0, 1'b1, 32'hAAAA_AAAA); #1;
      chk("rs_late_stall", {31'b0, stall_req}, 32'h0);
      next_cycle(); bus(1'b0, 1'b0, 32'h0); #1;
      chk("rs_late_drdata", data_sram_rdata, 32'h0);
      chk("rs_late_req", {31'b0, mem.mem_req}, 32'h0);
      chk("rs_late_stall2", {31'b0, stall_req}, 32'h0);

      // back-to-back fetches
      acc0 = n_acc;
      for (int k = 0; k < 3; k++) begin
         next_cycle(); inst_sram_en = 1'b1; inst_sram_addr = 32'(k * 4); bus(1'b1, 1'b0, 32'h0); #1;
         chk("bb_idle_stall", {31'b0, stall_req}, 32'h1);
         chk("bb_idle_req", {31'b0, mem.mem_req}, 32'h0);
         next_cycle(); #1;
         chk("bb_addr", mem.mem_addr, 32'(k * 4));
         next_cycle(); bus(1'b0, 1'b1, 32'h100 + 32'(k * 4)); #1;
         chk("bb_irdata_prev", inst_sram_rdata, (k == 0) ? 32'h0 : 32'h100 + 32'((k - 1) * 4));
         next_cycle(); bus(1'b0, 1'b0, 32'h0); inst_sram_en = 1'b0; #1;
         chk("bb_done_stall", {31'b0, stall_req}, 32'h0);
         chk("bb_irdata", inst_sram_rdata, 32'h100 + 32'(k * 4));
      end
      next_cycle(); #1;
      chk("bb_nacc", n_acc - acc0, 32'd3);
      chk("bb_idle_end", {31'b0, stall_req}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
